// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order response buffer and redirect flush.
// Define FETCH_BTFN_EN for static backward-taken/forward-not-taken branch prediction.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_addr,
  output logic        instr_pred_taken,
  input  logic        instr_ready,
  output logic        misalign_err
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] P1       = PW'(1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_fifo_addr [BUF_DEPTH];
  logic [PW-1:0] r_fifo_wr, r_fifo_rd;
  logic [CW-1:0] r_inflight;
  logic [31:0]   r_buf_data [BUF_DEPTH];
  logic [31:0]   r_buf_addr [BUF_DEPTH];
  logic [PW-1:0] r_buf_wr, r_buf_rd;
  logic [CW-1:0] r_buf_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic          r_misalign;

  logic          w_req_fire, w_rsp_drop, w_rsp_keep, w_rsp_any, w_buf_wr, w_pop, w_pred;
  logic [31:0]   w_rsp_addr, w_pred_target;
  logic [CW-1:0] w_new_drop, w_drop_dec;

  assign imem_req_valid = !reset && (r_state == RUN) && ((r_inflight + r_buf_cnt) < LP_DEPTH);
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_rsp_drop     = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_keep     = imem_rsp_valid && (r_drop_cnt == '0) && (r_inflight != '0);
  assign w_rsp_any      = w_rsp_drop || w_rsp_keep;
  assign w_rsp_addr     = r_fifo_addr[r_fifo_rd];
  assign w_buf_wr       = w_rsp_keep && !redirect_valid;
  assign w_pop          = instr_valid && instr_ready;
  // Everything still owed by memory after this cycle becomes wrong-path on a redirect.
  assign w_new_drop     = r_drop_cnt + r_inflight + CW'(w_req_fire) - CW'(w_rsp_any);
  assign w_drop_dec     = r_drop_cnt - CW'(w_rsp_drop);

  assign instr_valid    = (r_buf_cnt != '0);
  assign instr_data     = r_buf_data[r_buf_rd];
  assign instr_addr     = r_buf_addr[r_buf_rd];
  assign misalign_err   = r_misalign;

`ifdef FETCH_BTFN_EN
  logic r_buf_pred [BUF_DEPTH];

  function automatic logic is_bwd_branch(input logic [31:0] d);
    return (d[6:0] == 7'b1100011) && d[31];
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] d);
    return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
  endfunction

  assign w_pred           = w_buf_wr && is_bwd_branch(imem_rsp_data);
  assign w_pred_target    = w_rsp_addr + b_imm(imem_rsp_data);
  assign instr_pred_taken = r_buf_pred[r_buf_rd];

  always_ff @(posedge clk) begin
    if (w_buf_wr) r_buf_pred[r_buf_wr] <= w_pred;
  end
`else
  assign w_pred           = 1'b0;
  assign w_pred_target    = 32'h0;
  assign instr_pred_taken = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_req_fire) r_fifo_addr[r_fifo_wr] <= r_pc;
    if (w_buf_wr) begin
      r_buf_data[r_buf_wr] <= imem_rsp_data;
      r_buf_addr[r_buf_wr] <= w_rsp_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_fifo_wr  <= '0;
      r_fifo_rd  <= '0;
      r_inflight <= '0;
      r_buf_wr   <= '0;
      r_buf_rd   <= '0;
      r_buf_cnt  <= '0;
      r_drop_cnt <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        r_pc       <= {redirect_pc[31:2], 2'b00};
        r_buf_wr   <= '0;
        r_buf_rd   <= '0;
        r_buf_cnt  <= '0;
        r_fifo_wr  <= '0;
        r_fifo_rd  <= '0;
        r_inflight <= '0;
        r_drop_cnt <= w_new_drop;
        r_state    <= (w_new_drop != '0) ? DRAIN : RUN;
      end else begin
        if (w_buf_wr) r_buf_wr <= r_buf_wr + P1;
        if (w_pop)    r_buf_rd <= r_buf_rd + P1;
        r_buf_cnt <= r_buf_cnt + CW'(w_buf_wr) - CW'(w_pop);
        // Older buffered words precede the predicted branch, so only in-flight fetches are wrong-path.
        if (w_pred) begin
          r_pc       <= {w_pred_target[31:2], 2'b00};
          r_fifo_wr  <= '0;
          r_fifo_rd  <= '0;
          r_inflight <= '0;
          r_drop_cnt <= w_new_drop;
          r_state    <= (w_new_drop != '0) ? DRAIN : RUN;
        end else begin
          if (w_req_fire) begin
            r_pc      <= r_pc + 32'd4;
            r_fifo_wr <= r_fifo_wr + P1;
          end
          if (w_rsp_keep) r_fifo_rd <= r_fifo_rd + P1;
          r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp_keep);
          r_drop_cnt <= w_drop_dec;
          r_state    <= (w_drop_dec == '0) ? RUN : DRAIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench; expected fetch stream derived from
// sequential PC semantics with redirects, against an in-order variable-latency memory.
module tb_fetch_unit;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        instr_pred_taken;
  logic        instr_ready;
  logic        misalign_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .instr_pred_taken(instr_pred_taken), .instr_ready(instr_ready), .misalign_err(misalign_err)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mem_q[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  logic [31:0] cons_addr[$];
  logic [31:0] cons_data[$];
  logic        cons_pred[$];
  logic        mis_log[$];
  int          cyc, last_due, lat_min, lat_max, first_valid_cyc, max_out;
  logic        special_en;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (special_en && a == 32'h40) return 32'hFE00_0EE3;
    return {a[24:0], 7'b0010011};
  endfunction

  // One clock: memory answers, outputs are sampled mid-cycle, then the edge passes.
  task automatic step();
    mreq_t m;
    int    lat;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) begin
        lat = int'($urandom_range(lat_max, lat_min));
        m.addr = imem_req_addr;
        m.due  = cyc + lat;
        if (m.due <= last_due) m.due = last_due + 1;
        last_due = m.due;
        mem_q.push_back(m);
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
      end
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid && instr_ready && !redirect_valid) begin
        cons_addr.push_back(instr_addr);
        cons_data.push_back(instr_data);
        cons_pred.push_back(instr_pred_taken);
      end
      mis_log.push_back(misalign_err);
      if (mem_q.size() > max_out) max_out = mem_q.size();
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_logs();
    mem_q.delete(); req_log.delete(); req_cyc.delete();
    cons_addr.delete(); cons_data.delete(); cons_pred.delete(); mis_log.delete();
    cyc = 0; last_due = -1; first_valid_cyc = -1; max_out = 0;
    lat_min = 1; lat_max = 1; special_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; instr_ready = 1'b1; imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; instr_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(negedge clk); #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid_during: got %0b want 0", imem_req_valid); end
    @(negedge clk);
    clear_logs();
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid_after: got %0b want 1", imem_req_valid); end
    checks++;
    if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL reset_req_addr: got %h want %h", imem_req_addr, RESET_PC); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %0b want 0", instr_valid); end
    checks++;
    if (instr_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b want 0", instr_pred_taken); end
    checks++;
    if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %0b want 0", misalign_err); end
    // Fill the buffer, then reset mid-operation.
    instr_ready = 1'b0;
    repeat (6) step();
    do_reset();
    #1;
    checks++;
    if (imem_req_addr !== RESET_PC || imem_req_valid !== 1'b1) begin
      errors++; $display("FAIL midreset_req: got valid %0b addr %h want 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL midreset_instr_valid: got %0b want 0", instr_valid); end
  endtask

  task automatic test_sequential();
    do_reset();
    repeat (12) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_log.size() <= i) begin errors++; $display("FAIL seq_req_%0d: missing, want %h", i, 4 * i); end
      else if (req_log[i] !== 32'(4 * i)) begin errors++; $display("FAIL seq_req_%0d: got %h want %h", i, req_log[i], 4 * i); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cons_addr.size() <= i) begin errors++; $display("FAIL seq_instr_%0d: missing", i); end
      else if (cons_addr[i] !== 32'(4 * i) || cons_data[i] !== mem_word(32'(4 * i))) begin
        errors++; $display("FAIL seq_instr_%0d: got %h/%h want %h/%h", i, cons_addr[i], cons_data[i], 4 * i, mem_word(32'(4 * i)));
      end
    end
    checks++;
    if (first_valid_cyc != 2) begin errors++; $display("FAIL seq_first_valid_cycle: got %0d want 2", first_valid_cyc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    repeat (10) step();
    checks++;
    if (req_log.size() != BUF_DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d want %0d", req_log.size(), BUF_DEPTH); end
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled: got %0b want 0", imem_req_valid); end
    checks++;
    if (instr_valid !== 1'b1 || instr_addr !== 32'h0) begin
      errors++; $display("FAIL bp_head: got valid %0b addr %h want 1 00000000", instr_valid, instr_addr);
    end
    instr_ready = 1'b1;
    repeat (20) step();
    checks++;
    if (req_log.size() < 3) begin errors++; $display("FAIL bp_resume: only %0d requests", req_log.size()); end
    else if (req_log[2] !== 32'h8) begin errors++; $display("FAIL bp_resume: got %h want 00000008", req_log[2]); end
    checks++;
    if (cons_addr.size() < 6) begin errors++; $display("FAIL bp_progress: got %0d words want >=6", cons_addr.size()); end
    for (int i = 0; i < cons_addr.size(); i++) begin
      checks++;
      if (cons_addr[i] !== 32'(4 * i) || cons_data[i] !== mem_word(32'(4 * i))) begin
        errors++; $display("FAIL bp_stream_%0d: got %h/%h want %h", i, cons_addr[i], cons_data[i], 4 * i);
      end
    end
  endtask

  task automatic test_redirect_drop();
    do_reset();
    lat_min = 3; lat_max = 3;
    repeat (2) step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    repeat (14) step();
    checks++;
    if (req_log.size() < 3) begin errors++; $display("FAIL rd_req: only %0d requests", req_log.size()); end
    else if (req_log[2] !== 32'h100 || req_cyc[2] != 5) begin
      errors++; $display("FAIL rd_req: got %h at cycle %0d want 00000100 at 5", req_log[2], req_cyc[2]);
    end
    checks++;
    if (first_valid_cyc != 9) begin errors++; $display("FAIL rd_first_valid_cycle: got %0d want 9", first_valid_cyc); end
    checks++;
    if (cons_addr.size() < 2) begin errors++; $display("FAIL rd_stream: only %0d words", cons_addr.size()); end
    else if (cons_addr[0] !== 32'h100 || cons_addr[1] !== 32'h104) begin
      errors++; $display("FAIL rd_stream: got %h %h want 00000100 00000104", cons_addr[0], cons_addr[1]);
    end
  endtask

  task automatic test_misalign();
    int n0, k1;
    do_reset();
    repeat (3) step();
    n0 = cons_addr.size();
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    k1 = req_log.size();
    repeat (15) step();
    checks++;
    if (mis_log[3] !== 1'b0 || mis_log[4] !== 1'b1 || mis_log[5] !== 1'b0) begin
      errors++; $display("FAIL mis_pulse: got %0b%0b%0b want 010", mis_log[3], mis_log[4], mis_log[5]);
    end
    checks++;
    if (req_log.size() <= k1) begin errors++; $display("FAIL mis_req: missing"); end
    else if (req_log[k1] !== 32'h100) begin errors++; $display("FAIL mis_req: got %h want 00000100", req_log[k1]); end
    checks++;
    if (cons_addr.size() <= n0) begin errors++; $display("FAIL mis_instr: missing"); end
    else if (cons_addr[n0] !== 32'h100) begin errors++; $display("FAIL mis_instr: got %h want 00000100", cons_addr[n0]); end
  endtask

  task automatic test_wrap();
    int n0, k1;
    do_reset();
    n0 = cons_addr.size();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    k1 = req_log.size();
    repeat (12) step();
    checks++;
    if (req_log.size() < k1 + 2) begin errors++; $display("FAIL wrap_req: only %0d requests", req_log.size()); end
    else if (req_log[k1] !== 32'hFFFF_FFFC || req_log[k1 + 1] !== 32'h0) begin
      errors++; $display("FAIL wrap_req: got %h %h want fffffffc 00000000", req_log[k1], req_log[k1 + 1]);
    end
    checks++;
    if (cons_addr.size() < n0 + 2) begin errors++; $display("FAIL wrap_instr: only %0d words", cons_addr.size()); end
    else if (cons_addr[n0] !== 32'hFFFF_FFFC || cons_addr[n0 + 1] !== 32'h0 || cons_data[n0 + 1] !== mem_word(32'h0)) begin
      errors++; $display("FAIL wrap_instr: got %h %h want fffffffc 00000000", cons_addr[n0], cons_addr[n0 + 1]);
    end
  endtask

  task automatic test_btfn();
    int          n0;
    logic [31:0] ea [3];
    logic        ep [3];
`ifdef FETCH_BTFN_EN
    ea[0] = 32'h40; ea[1] = 32'h3C; ea[2] = 32'h40;
    ep[0] = 1'b1;   ep[1] = 1'b0;   ep[2] = 1'b1;
`else
    ea[0] = 32'h40; ea[1] = 32'h44; ea[2] = 32'h48;
    ep[0] = 1'b0;   ep[1] = 1'b0;   ep[2] = 1'b0;
`endif
    do_reset();
    special_en = 1'b1;
    n0 = cons_addr.size();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    repeat (16) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cons_addr.size() <= n0 + i) begin errors++; $display("FAIL btfn_%0d: missing, want %h", i, ea[i]); end
      else if (cons_addr[n0 + i] !== ea[i] || cons_pred[n0 + i] !== ep[i] || cons_data[n0 + i] !== mem_word(ea[i])) begin
        errors++; $display("FAIL btfn_%0d: got %h pred %0b data %h want %h pred %0b data %h",
                           i, cons_addr[n0 + i], cons_pred[n0 + i], cons_data[n0 + i], ea[i], ep[i], mem_word(ea[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_next, tgt, a, d;
    logic        p, exp_mis, red;
    int          ncons;
    do_reset();
    lat_min = 1; lat_max = 3;
    exp_next = RESET_PC; exp_mis = 1'b0; ncons = 0;
    for (int i = 0; i < 2000; i++) begin
      imem_req_ready = ($urandom_range(9, 0) < 7);
      instr_ready    = ($urandom_range(9, 0) < 6);
      red            = ($urandom_range(99, 0) < 4);
      tgt            = $urandom;
      if ($urandom_range(3, 0) != 0) tgt[1:0] = 2'b00;
      redirect_valid = red; redirect_pc = tgt;
      step();
      redirect_valid = 1'b0;
      while (cons_addr.size() > 0) begin
        a = cons_addr.pop_front(); d = cons_data.pop_front(); p = cons_pred.pop_front();
        checks++;
        if (a !== exp_next || d !== mem_word(exp_next) || p !== 1'b0) begin
          errors++; $display("FAIL rand_instr_%0d: got %h/%h pred %0b want %h/%h pred 0", ncons, a, d, p, exp_next, mem_word(exp_next));
        end
        exp_next = exp_next + 32'd4;
        ncons++;
      end
      checks++;
      if (mis_log[mis_log.size() - 1] !== exp_mis) begin
        errors++; $display("FAIL rand_misalign_cyc%0d: got %0b want %0b", i, mis_log[mis_log.size() - 1], exp_mis);
      end
      exp_mis = red && (tgt[1:0] != 2'b00);
      if (red) exp_next = {tgt[31:2], 2'b00};
    end
    checks++;
    if (max_out > BUF_DEPTH) begin errors++; $display("FAIL rand_credit: outstanding %0d exceeds %0d", max_out, BUF_DEPTH); end
    checks++;
    if (ncons < 100) begin errors++; $display("FAIL rand_progress: got %0d words want >=100", ncons); end
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; instr_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    clear_logs();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_misalign();
    test_wrap();
    test_btfn();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the RV32G single-cycle/pipelined core. Produces the instruction address stream, issues requests to instruction memory with a valid/ready handshake, and buffers returned instruction words for decode. It is the consumer of the branch unit's next-PC result: when execute resolves a control-flow change, `redirect_valid`/`redirect_pc` steer the PC and all wrong-path fetches are discarded.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `BUF_DEPTH`, 2, instruction buffer entries (power of 2, ≥2); also the max outstanding requests.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  instruction word returned (in order, latency ≥1, no backpressure).
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  execute-stage PC redirect (taken branch/jump/mispredict).
- `redirect_pc`  in  32  new PC.
- `instr_valid`  out  1  buffered instruction available.
- `instr_data`  out  32  instruction word at buffer head.
- `instr_addr`  out  32  PC of `instr_data`.
- `instr_pred_taken`  out  1  fetch predicted this branch taken.
- `instr_ready`  in  1  decode consumes head this cycle.
- `misalign_err`  out  1  one-cycle pulse: redirect target had `[1:0]`≠0.

## Operation
- State: `pc` (32b), in-flight address FIFO, instruction buffer (`BUF_DEPTH`), `inflight` counter, `drop_cnt` counter, FSM {`RUN`, `DRAIN`}.
- Credit rule: `imem_req_valid` = (state==`RUN`) && (`inflight` + buffer occupancy < `BUF_DEPTH`). Guarantees every response has a buffer slot.
- Request handshake (valid&&ready): push `pc` into in-flight FIFO, `inflight`+1, `pc` ← `pc`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0).
- Response: if `drop_cnt`>0, discard and decrement; else pop in-flight FIFO and write {data, addr, pred} to buffer.
- Decode handshake (`instr_valid`&&`instr_ready`): pop buffer head.
- External redirect: `pc` ← {`redirect_pc`[31:2],2'b00}; buffer flushed; `drop_cnt` ← in-flight count after this cycle's request/response accounting (a request accepted the same cycle counts; a response arriving the same cycle is dropped); in-flight FIFO cleared; state ← `DRAIN` if new `drop_cnt`>0 else `RUN`. `misalign_err` pulses if `redirect_pc[1:0]`≠0.
- `DRAIN` → `RUN` when `drop_cnt` reaches 0; no requests issued in `DRAIN`.
- Redirect has priority over decode pop, response write, and internal prediction in the same cycle.

## Timing
- Reset values: `pc`=`RESET_PC`, state=`RUN`, counters 0, buffers empty; `imem_req_valid`=1 in first cycle after reset deasserts (0 while `reset` high), `instr_valid`=0, `instr_pred_taken`=0, `misalign_err`=0, `imem_req_addr`=`RESET_PC`.
- Reset mid-operation: all in-flight responses arriving after reset are ignored only if memory is also reset; fetch unit itself returns to reset state in one cycle.
- `imem_req_addr` = `pc` combinationally; stable while valid && !ready.
- Response at cycle N → `instr_valid` at N+1 (buffer registered; head read combinational).
- Redirect at cycle N → first request to new PC at N+1 if `drop_cnt`=0, else cycle after last dropped response.
- Full buffer with `instr_ready`=0: requests stop; responses never lost.

## Configuration
- `FETCH_BTFN_EN` defined: static backward-taken/forward-not-taken prediction. On writing a response whose opcode `[6:0]`=7'b1100011 and `[31]`=1, compute B-immediate (sign-extended, bit 0 = 0), set entry's `pred_taken`=1, and perform an internal redirect to addr+imm exactly as above except this entry is kept. External redirect in same cycle wins. Branch unit must redirect to addr+4 on a not-taken predicted branch.
- Not defined: purely sequential fetch; `instr_pred_taken` tied 0; no opcode inspection logic.

## Test plan
- Reset, `imem_req_ready`=1, 1-cycle memory, `instr_ready`=1 → addresses 0,4,8,12 issued; `instr_addr` 0,4,8 in order, one per cycle after fill.
- `instr_ready`=0 with BUF_DEPTH=2 → exactly 2 requests issued then `imem_req_valid`=0; release → fetch resumes at 8, no word lost.
- Redirect to 32'h100 with 2 requests in flight → both responses dropped, `instr_valid` stays 0, next request 32'h100.
- Redirect to 32'h103 → `misalign_err` pulses one cycle, fetch at 32'h100.
- `pc`=32'hFFFF_FFFC → next request 32'h0000_0000.
- `FETCH_BTFN_EN`: word 32'hFE000EE3 (beq x0,x0,-4) at 32'h40 → `instr_pred_taken`=1, next fetch 32'h3C; with macro off, next fetch 32'h44 and `instr_pred_taken`=0.
